// File: rtl/gx4000_pkg.sv
// Shared definitions for the GX4000/Plus cartridge image ioctl channel.
// Both the header loader and the upload (readback) block use these offsets,
// so the 32-byte header image has a single definition.
package gx4000_pkg;

    localparam int HDR_LEN = 32;

    // Byte offsets of the little-endian header fields.
    localparam logic [4:0] OFS_TYPE  = 5'd0;
    localparam logic [4:0] OFS_SIZE  = 5'd1;
    localparam logic [4:0] OFS_CSUM  = 5'd3;
    localparam logic [4:0] OFS_VER   = 5'd5;
    localparam logic [4:0] OFS_DATE  = 5'd6;
    localparam logic [4:0] OFS_TITLE = 5'd10;

    localparam logic [7:0] PAD_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        MEM  = 2'd2,
        PAD  = 2'd3
    } upl_state_e;

endpackage

// File: rtl/gx4000_hdr_byte_sel.sv
// Combinational selection of one byte of the 32-byte cartridge header image
// from the parsed header fields. Bytes 18..31 are zero.
module gx4000_hdr_byte_sel
    import gx4000_pkg::*;
(
    input  logic [4:0]  idx_i,
    input  logic [7:0]  rom_type_i,
    input  logic [15:0] rom_size_i,
    input  logic [15:0] rom_checksum_i,
    input  logic [7:0]  rom_version_i,
    input  logic [31:0] rom_date_i,
    input  logic [63:0] rom_title_i,
    output logic [7:0]  byte_o
);

    logic [4:0] title_ofs_s;

    // Map the byte index onto the little-endian field layout.
    always_comb begin
        byte_o      = 8'h00;
        title_ofs_s = idx_i - OFS_TITLE;
        case (idx_i)
            OFS_TYPE:         byte_o = rom_type_i;
            OFS_SIZE:         byte_o = rom_size_i[7:0];
            OFS_SIZE + 5'd1:  byte_o = rom_size_i[15:8];
            OFS_CSUM:         byte_o = rom_checksum_i[7:0];
            OFS_CSUM + 5'd1:  byte_o = rom_checksum_i[15:8];
            OFS_VER:          byte_o = rom_version_i;
            OFS_DATE:         byte_o = rom_date_i[7:0];
            OFS_DATE + 5'd1:  byte_o = rom_date_i[15:8];
            OFS_DATE + 5'd2:  byte_o = rom_date_i[23:16];
            OFS_DATE + 5'd3:  byte_o = rom_date_i[31:24];
            default: begin
                if ((idx_i >= OFS_TITLE) && (idx_i < (OFS_TITLE + 5'd8))) begin
                    byte_o = rom_title_i[{title_ofs_s[2:0], 3'b000} +: 8];
                end else begin
                    byte_o = 8'h00;
                end
            end
        endcase
    end

endmodule

// File: rtl/gx4000_rom_upload.sv
// Serves ioctl upload (core-to-HPS) reads of a GX4000/Plus cartridge image:
// addresses below HDR_LEN return the rebuilt header, the payload range is
// fetched from cartridge memory over a request/ack handshake, anything else
// returns the pad byte and raises a sticky error. In-order payload bytes are
// summed and the sum is compared with the header checksum at completion.
module gx4000_rom_upload #(
    parameter int ADDR_W  = 25,
    parameter int HDR_LEN = gx4000_pkg::HDR_LEN
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic [7:0]        rom_type,
    input  logic [15:0]       rom_size,
    input  logic [15:0]       rom_checksum,
    input  logic [7:0]        rom_version,
    input  logic [31:0]       rom_date,
    input  logic [63:0]       rom_title,
    output logic              mem_rd,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,
    output logic              upload_done,
    output logic [15:0]       upload_checksum,
    output logic              checksum_ok,
    output logic              upload_error
);

    import gx4000_pkg::*;

    localparam logic [ADDR_W:0] HDR_LEN_X = (ADDR_W + 1)'(HDR_LEN);

    upl_state_e  state_q;
    logic [7:0]  din_q;
    logic        wait_q;
    logic        mem_rd_q;
    logic [15:0] mem_addr_q;
    logic        done_q;
    logic [15:0] sum_q;
    logic [15:0] next_ofs_q;
    logic        ok_q;
    logic        err_q;
    logic        upload_prev_q;

    logic            start_s;
    logic [ADDR_W:0] addr_ext_s;
    logic [ADDR_W:0] pay_end_s;
    logic            is_hdr_s;
    logic            is_pay_s;
    logic            is_last_hdr_s;
    logic [15:0]     ofs_s;
    logic [15:0]     sum_cur_s;
    logic [15:0]     next_cur_s;
    logic [15:0]     sum_add_s;
    logic [15:0]     last_ofs_s;
    logic [7:0]      hdr_byte_s;

    gx4000_hdr_byte_sel u_hdr_sel (
        .idx_i          (ioctl_addr[4:0]),
        .rom_type_i     (rom_type),
        .rom_size_i     (rom_size),
        .rom_checksum_i (rom_checksum),
        .rom_version_i  (rom_version),
        .rom_date_i     (rom_date),
        .rom_title_i    (rom_title),
        .byte_o         (hdr_byte_s)
    );

    // Address classification and the accumulator values as seen after any
    // upload-start clear that lands on the same edge.
    always_comb begin
        start_s       = ioctl_upload & ~upload_prev_q;
        addr_ext_s    = {1'b0, ioctl_addr};
        pay_end_s     = HDR_LEN_X + {{(ADDR_W - 15){1'b0}}, rom_size};
        is_hdr_s      = (addr_ext_s < HDR_LEN_X);
        is_pay_s      = (!is_hdr_s) && (addr_ext_s < pay_end_s);
        is_last_hdr_s = (addr_ext_s == (HDR_LEN_X - 1'b1));
        ofs_s         = 16'(ioctl_addr - ADDR_W'(HDR_LEN));
        sum_cur_s     = start_s ? 16'h0000 : sum_q;
        next_cur_s    = start_s ? 16'h0000 : next_ofs_q;
        sum_add_s     = sum_cur_s + {8'h00, mem_dout};
        last_ofs_s    = rom_size - 16'd1;
    end

    // Request FSM with registered outputs and in-order checksum accumulation.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            din_q         <= 8'h00;
            wait_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= 16'h0000;
            done_q        <= 1'b0;
            sum_q         <= 16'h0000;
            next_ofs_q    <= 16'h0000;
            ok_q          <= 1'b0;
            err_q         <= 1'b0;
            upload_prev_q <= 1'b0;
        end else begin
            upload_prev_q <= ioctl_upload;
            done_q        <= 1'b0;
            if (start_s) begin
                sum_q      <= 16'h0000;
                next_ofs_q <= 16'h0000;
                ok_q       <= 1'b0;
                err_q      <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (ioctl_upload && ioctl_rd) begin
                        if (is_hdr_s) begin
                            din_q   <= hdr_byte_s;
                            state_q <= HDR;
                            // An empty image completes on the last header byte.
                            if ((rom_size == 16'd0) && is_last_hdr_s) begin
                                done_q <= 1'b1;
                                ok_q   <= (sum_cur_s == rom_checksum);
                            end
                        end else if (is_pay_s) begin
                            mem_addr_q <= ofs_s;
                            mem_rd_q   <= 1'b1;
                            wait_q     <= 1'b1;
                            state_q    <= MEM;
                        end else begin
                            din_q   <= PAD_BYTE;
                            err_q   <= 1'b1;
                            state_q <= PAD;
                        end
                    end
                end
                HDR, PAD: begin
                    state_q <= IDLE;
                end
                MEM: begin
                    if (!ioctl_upload) begin
                        // Upload window closed: abandon the fetch, sum untouched.
                        mem_rd_q <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (mem_ack) begin
                        din_q    <= mem_dout;
                        mem_rd_q <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= IDLE;
                        // Only the next in-order byte contributes to the sum.
                        if (mem_addr_q == next_cur_s) begin
                            sum_q      <= sum_add_s;
                            next_ofs_q <= next_cur_s + 16'd1;
                            if (mem_addr_q == last_ofs_s) begin
                                done_q <= 1'b1;
                                ok_q   <= (sum_add_s == rom_checksum);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ioctl_din       = din_q;
    assign ioctl_wait      = wait_q;
    assign mem_rd          = mem_rd_q;
    assign mem_addr        = mem_addr_q;
    assign upload_done     = done_q;
    assign upload_checksum = sum_q;
    assign checksum_ok     = ok_q;
    assign upload_error    = err_q;

endmodule

// File: tb/tb_gx4000_rom_upload.sv
// Self-checking bench for gx4000_rom_upload: directed scenarios plus
// randomized uploads checked against a byte-level reference model.
module tb_gx4000_rom_upload;

    localparam int ADDR_W = 25;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [7:0]        rom_type;
    logic [15:0]       rom_size;
    logic [15:0]       rom_checksum;
    logic [7:0]        rom_version;
    logic [31:0]       rom_date;
    logic [63:0]       rom_title;
    logic              mem_rd;
    logic [15:0]       mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_dout;
    logic              upload_done;
    logic [15:0]       upload_checksum;
    logic              checksum_ok;
    logic              upload_error;

    gx4000_rom_upload #(.ADDR_W(ADDR_W), .HDR_LEN(32)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ioctl_upload    (ioctl_upload),
        .ioctl_rd        (ioctl_rd),
        .ioctl_addr      (ioctl_addr),
        .ioctl_din       (ioctl_din),
        .ioctl_wait      (ioctl_wait),
        .rom_type        (rom_type),
        .rom_size        (rom_size),
        .rom_checksum    (rom_checksum),
        .rom_version     (rom_version),
        .rom_date        (rom_date),
        .rom_title       (rom_title),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_dout        (mem_dout),
        .upload_done     (upload_done),
        .upload_checksum (upload_checksum),
        .checksum_ok     (checksum_ok),
        .upload_error    (upload_error)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] mem_img [0:511];
    logic [7:0] hdr_img [0:31];
    int         m_sum;
    int         m_next;
    bit         m_ok;
    bit         m_err;
    logic [7:0] m_din;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Header image as one packed little-endian record.
    task automatic build_hdr();
        logic [255:0] img;
        img = {112'h0, rom_title, rom_date, rom_version, rom_checksum, rom_size, rom_type};
        for (int i = 0; i < 32; i++) hdr_img[i] = img[8*i +: 8];
    endtask

    task automatic start_upload();
        build_hdr();
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
        m_sum = 0; m_next = 0; m_ok = 1'b0; m_err = 1'b0;
        check_val("start_clr_sum", upload_checksum, 32'(m_sum));
        check_val("start_clr_err", upload_error, 32'(m_err));
    endtask

    task automatic do_read(input int addr, input int dly);
        bit         exp_done;
        logic [7:0] exp_din;
        int         off;
        exp_done = 1'b0;
        ioctl_addr = ADDR_W'(addr);
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        if (addr < 32) begin
            exp_din = hdr_img[addr];
            if (rom_size == 16'd0 && addr == 31) begin
                exp_done = 1'b1;
                m_ok = (m_sum == int'(rom_checksum));
            end
        end else if (addr < 32 + int'(rom_size)) begin
            off = addr - 32;
            check_val("mem_rd_req", mem_rd, 32'd1);
            check_val("wait_req", ioctl_wait, 32'd1);
            check_val("mem_addr", mem_addr, 32'(off));
            for (int d = 0; d < dly; d++) begin
                tick();
                check_val("wait_hold", ioctl_wait, 32'd1);
                check_val("mem_addr_hold", mem_addr, 32'(off));
            end
            mem_dout = mem_img[off];
            mem_ack  = 1'b1;
            tick();
            mem_ack  = 1'b0;
            mem_dout = 8'($urandom);
            exp_din  = mem_img[off];
            check_val("mem_rd_drop", mem_rd, 32'd0);
            if (off == m_next) begin
                m_sum  = (m_sum + int'(exp_din)) & 16'hFFFF;
                m_next = m_next + 1;
                if (m_next == int'(rom_size)) begin
                    exp_done = 1'b1;
                    m_ok = (m_sum == int'(rom_checksum));
                end
            end
        end else begin
            exp_din = 8'hFF;
            m_err   = 1'b1;
        end
        m_din = exp_din;
        check_val("din", ioctl_din, 32'(exp_din));
        check_val("wait", ioctl_wait, 32'd0);
        check_val("done", upload_done, 32'(exp_done));
        check_val("csum", upload_checksum, 32'(m_sum));
        check_val("ok", checksum_ok, 32'(m_ok));
        check_val("err", upload_error, 32'(m_err));
        tick();
        check_val("done_pulse", upload_done, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_din"}, ioctl_din, 32'd0);
        check_val({tag, "_wait"}, ioctl_wait, 32'd0);
        check_val({tag, "_mem_rd"}, mem_rd, 32'd0);
        check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_val({tag, "_done"}, upload_done, 32'd0);
        check_val({tag, "_csum"}, upload_checksum, 32'd0);
        check_val({tag, "_ok"}, checksum_ok, 32'd0);
        check_val({tag, "_err"}, upload_error, 32'd0);
    endtask

    initial begin
        logic [7:0] exp10 [0:9];
        int         dly4 [0:3];
        int         addr;
        int         tsum;
        exp10 = '{8'h01, 8'h04, 8'h00, 8'h23, 8'h01, 8'h07, 8'h31, 8'h01, 8'h24, 8'h20};
        dly4  = '{0, 3, 1, 5};

        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
        mem_ack = 1'b0; mem_dout = 8'h00;
        rom_type = 8'h01; rom_size = 16'h0004; rom_checksum = 16'h0123;
        rom_version = 8'h07; rom_date = 32'h20240131; rom_title = "GX4000AB";
        mem_img[0] = 8'h10; mem_img[1] = 8'h20; mem_img[2] = 8'h40; mem_img[3] = 8'hB3;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        m_din = 8'h00;

        // Header readback.
        start_upload();
        for (int i = 0; i < 32; i++) begin
            do_read(i, 0);
            if (i < 10) check_val("hdr_const", ioctl_din, 32'(exp10[i]));
        end

        // In-order payload with a mid-stream re-read of address 33.
        do_read(32, dly4[0]);
        do_read(33, dly4[1]);
        do_read(34, dly4[2]);
        do_read(33, 2);
        check_val("reread_sum", upload_checksum, 32'h0000_0070);
        do_read(35, dly4[3]);
        check_val("stream_sum", upload_checksum, 32'h0000_0123);
        check_val("stream_ok", checksum_ok, 32'd1);

        // Out of range: sticky until the next upload start.
        do_read(36, 0);
        check_val("oor_err", upload_error, 32'd1);
        do_read(5, 0);
        check_val("oor_err_hold", upload_error, 32'd1);

        // Wrong header checksum.
        rom_checksum = 16'h0124;
        start_upload();
        for (int i = 0; i < 4; i++) do_read(32 + i, i);
        check_val("bad_csum_ok", checksum_ok, 32'd0);

        // Empty payload completes on header byte 31.
        rom_size = 16'd0; rom_checksum = 16'd0;
        start_upload();
        do_read(30, 0);
        do_read(31, 0);

        // Abort during MEM; a late ack is ignored.
        rom_size = 16'd4; rom_checksum = 16'h0123;
        start_upload();
        do_read(3, 0);
        ioctl_addr = ADDR_W'(32); ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        check_val("abort_mem_rd_up", mem_rd, 32'd1);
        ioctl_upload = 1'b0;
        tick();
        check_val("abort_mem_rd", mem_rd, 32'd0);
        check_val("abort_wait", ioctl_wait, 32'd0);
        mem_dout = 8'h5A; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_val("abort_din", ioctl_din, 32'(m_din));
        check_val("abort_sum", upload_checksum, 32'(m_sum));
        check_val("abort_done", upload_done, 32'd0);

        // Reset in the middle of a payload fetch.
        start_upload();
        ioctl_addr = ADDR_W'(33); ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        check_val("rst_mem_rd_up", mem_rd, 32'd1);
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        m_din = 8'h00;

        // 300 bytes of FF wrap the sum.
        rom_size = 16'd300; rom_checksum = 16'h2AD4;
        for (int i = 0; i < 300; i++) mem_img[i] = 8'hFF;
        start_upload();
        for (int i = 0; i < 300; i++) do_read(32 + i, int'($urandom_range(0, 2)));
        check_val("wrap_sum", upload_checksum, 32'h0000_2AD4);
        check_val("wrap_ok", checksum_ok, 32'd1);

        // Randomized uploads against the reference model.
        for (int u = 0; u < 8; u++) begin
            rom_type = 8'($urandom); rom_version = 8'($urandom);
            rom_date = $urandom; rom_title = {$urandom, $urandom};
            rom_size = 16'($urandom_range(1, 24));
            tsum = 0;
            for (int i = 0; i < int'(rom_size); i++) begin
                mem_img[i] = 8'($urandom);
                tsum = tsum + int'(mem_img[i]);
            end
            rom_checksum = (u % 2 == 0) ? 16'(tsum) : 16'($urandom);
            start_upload();
            for (int k = 0; k < 3 * int'(rom_size) + 4; k++) begin
                if ($urandom_range(0, 9) < 6 && m_next < int'(rom_size)) addr = 32 + m_next;
                else addr = int'($urandom_range(0, 32 + int'(rom_size) + 8));
                do_read(addr, int'($urandom_range(0, 4)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
